// File: rtl/tdm_demux_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tdm_demux_driver: serialises an accepted 8-bit word to the enabled channels
// of a downstream 1-to-8 demux, one bit per clock, in scan order.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tdm_demux_driver #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic [7:0] in_mask,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       a,
  output logic [2:0] sel,
  output logic       out_valid,
  output logic       frame_done
);

  logic [7:0] data_r;
  logic [7:0] pend;
  logic       done_r;

  logic [2:0] cur;
  logic       busy;
  logic       last;
  logic       accept;
  logic [7:0] pend_clr;

  // Priority pick of the next channel; the final matching iteration wins.
  generate
    if (LSB_FIRST) begin : g_lsb
      always_comb begin
        cur = 3'd0;
        for (int i = 7; i >= 0; i--) begin
          if (pend[i]) cur = 3'(i);
        end
      end
    end else begin : g_msb
      always_comb begin
        cur = 3'd0;
        for (int i = 0; i < 8; i++) begin
          if (pend[i]) cur = 3'(i);
        end
      end
    end
  endgenerate

  assign busy     = (pend != 8'd0);
  assign last     = busy && ((pend & (pend - 8'd1)) == 8'd0);
  assign in_ready = !busy || last;
  assign accept   = in_valid && in_ready;
  assign pend_clr = pend & ~(8'd1 << cur);

  assign out_valid  = busy;
  assign sel        = busy ? cur : 3'd0;
  assign a          = busy ? data_r[cur] : 1'b0;
  assign frame_done = done_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= 8'd0;
      pend   <= 8'd0;
      done_r <= 1'b0;
    end else begin
      // A new word loaded during LAST replaces the final-bit clear.
      if (accept) begin
        data_r <= in_data;
        pend   <= in_mask;
      end else if (busy) begin
        pend   <= pend_clr;
      end
      done_r <= last || (accept && (in_mask == 8'd0));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tdm_demux_driver: table-driven self-checking bench for tdm_demux_driver.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_tdm_demux_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] in_mask;

  logic       rdy_l, a_l, ov_l, fd_l;
  logic [2:0] sel_l;
  logic       rdy_m, a_m, ov_m, fd_m;
  logic [2:0] sel_m;

  tdm_demux_driver #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_mask(in_mask),
    .in_valid(in_valid), .in_ready(rdy_l), .a(a_l), .sel(sel_l),
    .out_valid(ov_l), .frame_done(fd_l)
  );

  tdm_demux_driver #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .in_data(in_data), .in_mask(in_mask),
    .in_valid(in_valid), .in_ready(rdy_m), .a(a_m), .sel(sel_m),
    .out_valid(ov_m), .frame_done(fd_m)
  );

  typedef struct {
    logic       r;
    logic       vld;
    logic [7:0] d;
    logic [7:0] m;
    logic       ov;
    logic       aa;
    logic [2:0] s;
    logic       rdy;
    logic       fd;
  } vec_t;

  vec_t vq[$];
  int   passed = 0;
  int   total  = 0;

  task automatic add(input logic r, input logic vld, input logic [7:0] d,
                     input logic [7:0] m, input logic ov, input logic aa,
                     input logic [2:0] s, input logic rdy, input logic fd);
    vec_t t;
    t.r = r; t.vld = vld; t.d = d; t.m = m;
    t.ov = ov; t.aa = aa; t.s = s; t.rdy = rdy; t.fd = fd;
    vq.push_back(t);
  endtask

  task automatic idle(input logic r, input logic vld, input logic [7:0] d,
                      input logic [7:0] m, input logic fd);
    add(r, vld, d, m, 1'b0, 1'b0, 3'd0, 1'b1, fd);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic r, input logic vld, input logic [7:0] d,
                       input logic [7:0] m);
    @(negedge clk);
    rst = r; in_valid = vld; in_data = d; in_mask = m;
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [6:0] act,
                     input logic [6:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: ov,a,sel,rdy,fd got %b want %b", nm, idx, act, exp);
  endtask

  initial begin
    logic [7:0] dat;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_mask = 8'd0;
    dat = 8'hA5;

    // Reset held two cycles with a word offered; nothing may be captured.
    idle(1, 1, 8'h5A, 8'hFF, 0);
    idle(1, 1, 8'h5A, 8'hFF, 0);
    idle(0, 0, 8'h00, 8'h00, 0);

    // Full frame A5/FF, ascending.
    idle(0, 1, 8'hA5, 8'hFF, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 8'h00, 8'h00, 1, dat[i], 3'(i), (i == 7), 0);
    idle(0, 0, 8'h00, 8'h00, 1);
    idle(0, 0, 8'h00, 8'h00, 0);

    // Sparse mask 24.
    idle(0, 1, 8'hFF, 8'h24, 0);
    add(0, 0, 8'h00, 8'h00, 1, 1, 3'd2, 0, 0);
    add(0, 0, 8'h00, 8'h00, 1, 1, 3'd5, 1, 0);
    idle(0, 0, 8'h00, 8'h00, 1);
    idle(0, 0, 8'h00, 8'h00, 0);

    // Back-to-back: second word held from cycle 2, taken in LAST (cycle 8).
    idle(0, 1, 8'hA5, 8'hFF, 0);
    add(0, 0, 8'h00, 8'h00, 1, dat[0], 3'd0, 0, 0);
    for (int i = 1; i < 8; i++) add(0, 1, 8'h01, 8'h81, 1, dat[i], 3'(i), (i == 7), 0);
    add(0, 0, 8'h00, 8'h00, 1, 1, 3'd0, 0, 1);
    add(0, 0, 8'h00, 8'h00, 1, 0, 3'd7, 1, 0);
    idle(0, 0, 8'h00, 8'h00, 1);
    idle(0, 0, 8'h00, 8'h00, 0);

    // Zero mask: accepted, no bits, one done pulse.
    idle(0, 1, 8'hFF, 8'h00, 0);
    idle(0, 0, 8'h00, 8'h00, 1);
    idle(0, 0, 8'h00, 8'h00, 0);

    // Single-channel frames accepted every cycle.
    idle(0, 1, 8'h08, 8'h08, 0);
    add(0, 1, 8'h00, 8'h40, 1, 1, 3'd3, 1, 0);
    add(0, 0, 8'h00, 8'h00, 1, 0, 3'd6, 1, 1);
    idle(0, 0, 8'h00, 8'h00, 1);

    // Abort after 3 bits: no further output and no done pulse.
    idle(0, 1, 8'hFF, 8'hFF, 0);
    add(0, 0, 8'h00, 8'h00, 1, 1, 3'd0, 0, 0);
    add(0, 0, 8'h00, 8'h00, 1, 1, 3'd1, 0, 0);
    add(1, 0, 8'h00, 8'h00, 1, 1, 3'd2, 0, 0);
    for (int i = 0; i < 9; i++) idle(0, 0, 8'h00, 8'h00, 0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].r, vq[i].vld, vq[i].d, vq[i].m);
      chk("lsb", i, {ov_l, a_l, sel_l, rdy_l, fd_l},
          {vq[i].ov, vq[i].aa, vq[i].s, vq[i].rdy, vq[i].fd});
    end

    // Descending scan on the LSB_FIRST=0 instance, mask 11, data 10.
    drive(0, 1, 8'h10, 8'h11);
    chk("msb", 0, {ov_m, a_m, sel_m, rdy_m, fd_m}, 7'b0_0_000_1_0);
    drive(0, 0, 8'h00, 8'h00);
    chk("msb", 1, {ov_m, a_m, sel_m, rdy_m, fd_m}, 7'b1_1_100_0_0);
    drive(0, 0, 8'h00, 8'h00);
    chk("msb", 2, {ov_m, a_m, sel_m, rdy_m, fd_m}, 7'b1_0_000_1_0);
    drive(0, 0, 8'h00, 8'h00);
    chk("msb", 3, {ov_m, a_m, sel_m, rdy_m, fd_m}, 7'b0_0_000_1_1);
    drive(0, 0, 8'h00, 8'h00);
    chk("msb", 4, {ov_m, a_m, sel_m, rdy_m, fd_m}, 7'b0_0_000_1_0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tdm_demux_driver.md
# tdm_demux_driver

Time-division driver that sits directly upstream of the 1-to-8 bit demultiplexer and generates its `a` data bit and `sel` channel index. It accepts an 8-bit word plus an 8-bit channel-enable mask over a valid/ready handshake. It then emits one bit per clock to each enabled channel in scan order, skipping disabled channels without idle cycles. When no bit is being emitted, it drives `a=0` and `sel=0`, so the downstream demux output is all zeros.

## Interface
- `LSB_FIRST`, default 1: 1 = scan channels ascending (0→7); 0 = scan descending (7→0).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  word; bit i goes to channel i.
- `in_mask`  in  8  channel enable; bit i = 1 means channel i is sent.
- `in_valid`  in  1  word/mask present.
- `in_ready`  out  1  driver can accept a word this cycle.
- `a`  out  1  data bit to the demux.
- `sel`  out  3  channel index to the demux.
- `out_valid`  out  1  `a`/`sel` carry a real bit this cycle.
- `frame_done`  out  1  one-cycle pulse after a frame's last bit.

## Operation
- Registers:
  - `data_r[7:0]`: the captured word.
  - `pend[7:0]`: channels still to send.
  - `done_r`: registered pulse that drives `frame_done`.
- States are implicit:
  - IDLE when `pend==0`.
  - SEND when `pend!=0`.
  - LAST when `pend` has exactly one bit set (a sub-case of SEND).
- Current channel `cur`:
  - `LSB_FIRST=1`: the lowest set bit of `pend`.
  - `LSB_FIRST=0`: the highest set bit of `pend`.
- Combinational outputs:
  - `out_valid = (pend!=0)`.
  - `sel = out_valid ? cur : 0`.
  - `a = out_valid ? data_r[cur] : 0`.
  - `in_ready = (pend==0) || (popcount(pend)==1)`, i.e. ready in IDLE or LAST.
- Accept = `in_valid && in_ready`. On accept, at the clock edge:
  - `data_r <= in_data`.
  - `pend <= in_mask`. This overrides the clearing of the last bit, so frames run back to back.
- No accept but SEND: `pend <= pend` with bit `cur` cleared.
- IDLE and no accept: `data_r` and `pend` hold.
- `done_r` is set to 1 when either:
  - the current cycle is LAST; or
  - the current cycle accepts a word with `in_mask==0`.
  
  Otherwise `done_r` is set to 0.
- `in_mask==0`: the word is accepted and discarded. No `out_valid` follows, and `frame_done` still pulses once.
- `in_valid` while `in_ready=0`: ignored. The source must hold `in_data`/`in_mask` until accepted.
- Changes to `in_data`/`in_mask` after acceptance have no effect on the frame in flight.

## Timing
- Reset (when `rst=1` at an edge): `data_r=0`, `pend=0`, `done_r=0`. Resulting outputs:
  - `a=0`, `sel=0`, `out_valid=0`, `frame_done=0`, `in_ready=1`.
- Reset mid-frame aborts the frame:
  - remaining bits are dropped;
  - `out_valid=0` from the cycle after the reset edge;
  - no `frame_done` for the aborted frame.
- Latency: a word accepted in cycle N has its first bit on `a`/`sel` with `out_valid=1` in cycle N+1.
- A frame with k enabled channels occupies exactly k consecutive `out_valid` cycles.
- `frame_done` is high for exactly one cycle:
  - in the cycle after the LAST cycle; or
  - in cycle N+1 for a zero-mask frame accepted in cycle N.
- Back-to-back frames: a word accepted during LAST starts in the next cycle with no gap in `out_valid`. That cycle also shows `frame_done=1` for the previous frame.
- Throughput: up to 8 bits per 8 cycles; 1 frame per cycle for single-channel masks.

## Test plan
- Reset check: assert `rst` for 2 cycles with `in_valid=1` → `out_valid=0`, `a=0`, `sel=0`, `frame_done=0`, `in_ready=1`; no word accepted.
- Full frame, `LSB_FIRST=1`, `in_data=8'hA5`, `in_mask=8'hFF`, accepted in cycle 0 → for cycles 1–8:
  - `sel=0..7`, `a=1,0,1,0,0,1,0,1`, `out_valid=1`;
  - `in_ready=1` only in cycle 8;
  - `frame_done=1` in cycle 9 only.
- Sparse mask, `in_data=8'hFF`, `in_mask=8'h24` → cycle 1: `sel=2`, `a=1`; cycle 2: `sel=5`, `a=1`, `in_ready=1`; cycle 3: `frame_done=1`, `out_valid=0`.
- Back-to-back frames:
  - second word `in_data=8'h01`, `in_mask=8'h81` is held valid from cycle 2 and accepted in cycle 8 (the LAST cycle of the full frame);
  - cycle 9: `sel=0`, `a=1`, `frame_done=1`;
  - cycle 10: `sel=7`, `a=0`;
  - cycle 11: `frame_done=1`.
- Zero mask, `in_mask=8'h00` accepted in cycle 0 → `out_valid` stays 0; `frame_done=1` in cycle 1; `in_ready` stays 1.
- Abort and direction:
  - `rst` asserted after 3 bits of an `8'hFF` mask → `out_valid=0` from the next cycle, and no `frame_done` afterwards.
  - `LSB_FIRST=0`, `in_mask=8'h11` → `sel=4`, then `sel=0`.
